// File: rtl/ped_pkg.sv
// Shared types and helpers for the pedestrian-crossing phase sequencer.
package ped_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WALK    = 3'd2,
    ST_CAUTION = 3'd3,
    ST_DONE    = 3'd4
  } ped_state_e;

  function automatic logic [63:0] ms_to_cycles(input logic [63:0] ms,
                                               input logic [63:0] clk_freq,
                                               input logic [63:0] ms_conv);
    return ms * (clk_freq / ms_conv);
  endfunction

endpackage

// File: rtl/ped_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-time debounce and
// a one-cycle pulse on each rising edge of the debounced level.
module ped_btn_debounce #(
  parameter int unsigned STABLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Down-counter runs only while the synchronized input disagrees with the
  // accepted level; any agreement restarts the stable window.
  always_comb begin
    level_d = level_q;
    cnt_d   = RELOAD;
    if (sync2_q != level_q) begin
      if (cnt_q == '0) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= RELOAD;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/ped_phase_sequencer.sv
// Pedestrian phase sequencer: requests a crossing phase, then runs WALK and a
// flashing CAUTION interval while publishing the countdown bus.
//
//   state   | meaning
//   IDLE    | no request outstanding
//   REQ     | ped_req high, waiting for conflicting traffic to stop
//   WALK    | walk lamp on, counting the free interval
//   CAUTION | don't-walk flashing, counting to the end of the phase
//   DONE    | phase complete, waiting for grant to be released
module ped_phase_sequencer
  import ped_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned MS_CONV     = 1000,
  parameter int unsigned WALK_MS     = 7000,
  parameter int unsigned CAUTION_MS  = 10000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned FLASH_MS    = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ped_btn,
  input  logic        ped_grant,
  output logic        ped_req,
  output logic        ped_done,
  output logic        walk_lamp,
  output logic        dont_walk_lamp,
  output logic        pd_caution,
  output logic [31:0] pd_counter,
  output logic [31:0] pd_total_cycles,
  output logic [31:0] pd_free_cycles
);

  localparam logic [63:0] FREE     = ms_to_cycles(64'(WALK_MS), 64'(CLK_FREQ), 64'(MS_CONV));
  localparam logic [63:0] TOTAL    = FREE + ms_to_cycles(64'(CAUTION_MS), 64'(CLK_FREQ), 64'(MS_CONV));
  localparam logic [63:0] FLASH    = ms_to_cycles(64'(FLASH_MS), 64'(CLK_FREQ), 64'(MS_CONV));
  localparam logic [63:0] DEBOUNCE = ms_to_cycles(64'(DEBOUNCE_MS), 64'(CLK_FREQ), 64'(MS_CONV));

  localparam logic [31:0] FREE_C  = FREE[31:0];
  localparam logic [31:0] TOTAL_C = TOTAL[31:0];
  localparam logic [31:0] FLASH_C = (FLASH == 64'd0) ? 32'd1 : FLASH[31:0];
  localparam int unsigned DB_C    = (DEBOUNCE == 64'd0) ? 1 : 32'(DEBOUNCE[31:0]);

  if (TOTAL >= 64'h0000_0001_0000_0000) begin : g_chk_total
    $error("ped_phase_sequencer: TOTAL cycle count does not fit in 32 bits");
  end
  if (FREE == 64'd0) begin : g_chk_free
    $error("ped_phase_sequencer: WALK interval must be at least one cycle");
  end
  if (CAUTION_MS == 0) begin : g_chk_caution
    $error("ped_phase_sequencer: CAUTION interval must be non-zero");
  end

  logic press;
  logic btn_level;

  ped_btn_debounce #(
    .STABLE_CYCLES (DB_C)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (ped_btn),
    .level_o (btn_level),
    .rise_o  (press)
  );

  ped_state_e  state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] flash_q, flash_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic        walk_q, walk_d;
  logic        dw_q, dw_d;
  logic        caut_q, caut_d;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;

    if (press && (state_q != ST_WALK)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_q) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ped_grant) begin
          state_d   = ST_WALK;
          pending_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_WALK: begin
        if (!ped_grant) begin
          state_d   = ST_REQ;
          pending_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q + 32'd1 == FREE_C) begin
          state_d = ST_CAUTION;
          cnt_d   = FREE_C;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_CAUTION: begin
        if (!ped_grant) begin
          state_d   = ST_REQ;
          pending_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == TOTAL_C - 32'd1) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DONE: begin
        if (!ped_grant) state_d = pending_d ? ST_REQ : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    req_d   = (state_d == ST_REQ);
    walk_d  = (state_d == ST_WALK);
    caut_d  = (state_d == ST_CAUTION);
    done_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
    dw_d    = (state_d != ST_WALK);
    flash_d = FLASH_C - 32'd1;
    if (state_d == ST_CAUTION && state_q == ST_CAUTION) begin
      if (flash_q == '0) begin
        dw_d = ~dw_q;
      end else begin
        dw_d    = dw_q;
        flash_d = flash_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      flash_q   <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      walk_q    <= 1'b0;
      dw_q      <= 1'b1;
      caut_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      flash_q   <= flash_d;
      req_q     <= req_d;
      done_q    <= done_d;
      walk_q    <= walk_d;
      dw_q      <= dw_d;
      caut_q    <= caut_d;
    end
  end

  assign ped_req         = req_q;
  assign ped_done        = done_q;
  assign walk_lamp       = walk_q;
  assign dont_walk_lamp  = dw_q;
  assign pd_caution      = caut_q;
  assign pd_counter      = cnt_q;
  assign pd_total_cycles = TOTAL_C;
  assign pd_free_cycles  = FREE_C;

endmodule

// File: doc/ped_phase_sequencer.md
# ped_phase_sequencer

Pedestrian-crossing phase sequencer for one crosswalk of the intersection controller. It conditions the raw push-button and requests a pedestrian phase from the main intersection FSM. Once the request is granted, it runs a timed WALK interval followed by a flashing CAUTION interval. It is the producer of the `pd_caution` / `pd_counter` / `pd_total_cycles` / `pd_free_cycles` bus that the countdown display logic consumes.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz
- MS_CONV, 1000, milliseconds per second
- WALK_MS, 7000, WALK (free) interval in ms
- CAUTION_MS, 10000, CAUTION interval in ms
- DEBOUNCE_MS, 20, time the button must be stable before a level change is accepted
- FLASH_MS, 500, half-period of the don't-walk flash during CAUTION

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ped_btn  in  1  raw, asynchronous push-button, active-high
- ped_grant  in  1  level from intersection FSM; high means conflicting traffic is red
- ped_req  out  1  level request to intersection FSM
- ped_done  out  1  one-cycle pulse when the phase completes normally
- walk_lamp  out  1  WALK indication
- dont_walk_lamp  out  1  DON'T WALK indication (steady or flashing)
- pd_caution  out  1  high throughout the CAUTION state
- pd_counter  out  32  cycles elapsed since WALK entry
- pd_total_cycles  out  32  constant TOTAL = FREE + CAUTION_MS*(CLK_FREQ/MS_CONV)
- pd_free_cycles  out  32  constant FREE = WALK_MS*(CLK_FREQ/MS_CONV)

## Operation
- Button path: 2-flop synchronizer, then debounce. The debounced level changes only after the input has been stable for DEBOUNCE_MS*(CLK_FREQ/MS_CONV) cycles. A press event is the rising edge of the debounced level.
- Press event sets a `pending` flag. Events in IDLE, REQ, CAUTION and DONE set `pending`. Events in WALK are discarded, because the crossing is already being served.
- States:
  - IDLE: `pending` moves the FSM to REQ.
  - REQ: `ped_req`=1. When `ped_grant`=1, go to WALK, clear `pending` and set `pd_counter`=0.
  - WALK: `pd_counter` increments by 1 each cycle. On the cycle it would become FREE, it loads FREE and the FSM enters CAUTION.
  - CAUTION: counting continues. On the cycle after `pd_counter`=TOTAL-1, go to DONE with `pd_counter`=0.
  - DONE: `ped_done`=1 for the first DONE cycle only. Wait for `ped_grant`=0, then go to REQ if `pending` is set, otherwise IDLE.
- Preemption: if `ped_grant` drops while in WALK or CAUTION, go to REQ on the next cycle. Clear the counter, do not pulse `ped_done`, and treat the request as still pending.
- `ped_grant` high in IDLE is ignored.
- Lamps:
  - WALK state: `walk_lamp`=1, `dont_walk_lamp`=0.
  - CAUTION state: `walk_lamp`=0. `dont_walk_lamp` starts at 1 on CAUTION entry and toggles every FLASH_MS*(CLK_FREQ/MS_CONV) cycles, using its own flash counter cleared on entry.
  - All other states: `walk_lamp`=0, `dont_walk_lamp`=1.
- Arithmetic: FREE and TOTAL are computed as 64-bit localparams. Elaboration fails if TOTAL ≥ 2^32, if FREE = 0, or if CAUTION_MS = 0.

## Timing
- Reset values:
  - state IDLE, `pending`=0, debounced level 0
  - `ped_req`=0, `ped_done`=0, `walk_lamp`=0, `dont_walk_lamp`=1, `pd_caution`=0, `pd_counter`=0
  - `pd_total_cycles` and `pd_free_cycles` hold their constant values even during reset
- All outputs are registered and change only on the clk edge.
- Press-event latency: `ped_req` rises 2 cycles after the press event (event → `pending` → REQ).
- Grant latency: the first WALK cycle is the cycle after `ped_grant` is sampled high in REQ.
- `pd_caution` and `pd_counter`=FREE become visible in the same cycle.
- Phase length: WALK lasts FREE cycles and CAUTION lasts TOTAL-FREE cycles, so `pd_counter` never exceeds TOTAL-1.
- Reset asserted mid-phase returns every output to its reset value immediately; no `ped_done` is produced.

## Structure
- Package `ped_pkg`:
  - state enum (IDLE, REQ, WALK, CAUTION, DONE)
  - function `ms_to_cycles(ms, clk_freq, ms_conv)` returning 64 bits
- Sub-module `ped_btn_debounce`: synchronizer, debounce counter and rising-edge pulse output. Parameter: stable-cycle count.

## Test plan
All scenarios use CLK_FREQ=1000, MS_CONV=1000, WALK_MS=5, CAUTION_MS=4, DEBOUNCE_MS=3, FLASH_MS=2, giving FREE=5 and TOTAL=9.
- Bounce: `ped_btn` toggles every cycle for 6 cycles, then stays low → `ped_req` stays 0. Hold high for 3+ cycles → `ped_req`=1 two cycles after the debounced edge.
- Full phase: grant held high →
  - WALK for 5 cycles with `pd_counter` 0..4 and `walk_lamp`=1
  - CAUTION with `pd_counter` 5..8 and `pd_caution`=1
  - `dont_walk_lamp` pattern 1,1,0,0
  - then `ped_done` pulses once with `pd_counter`=0
- DONE hold: keep grant high for 10 cycles after `ped_done` → FSM stays in DONE with no repeat pulse. Drop grant → IDLE.
- Press while in WALK → no new request after DONE. Press while in CAUTION → `ped_req`=1 right after grant drops in DONE.
- Preemption: drop grant at `pd_counter`=6 → next cycle REQ, `ped_req`=1, `pd_counter`=0, `pd_caution`=0, no `ped_done`.
- Reset asserted at `pd_counter`=3 → all outputs at reset values in the same cycle; `pd_free_cycles`=5 and `pd_total_cycles`=9 throughout.
